// File: rtl/sev_seg_stopwatch.sv
// rtl/sev_seg_stopwatch.sv - SS.hh BCD stopwatch supplying {dp_n, hex} digit buses to the segment driver
// Optional lap-hold display freeze is enabled by defining LAP_HOLD_EN.
module sev_seg_stopwatch #(
   parameter int CLK_HZ  = 50_000_000,
   parameter int TICK_HZ = 100
) (
   input  logic       clk_50MHz,
   input  logic       rst_n,
   input  logic       btn_start,
   input  logic       btn_clear,
   output logic [4:0] data_digit0,
   output logic [4:0] data_digit1,
   output logic [4:0] data_digit2,
   output logic [4:0] data_digit3,
   output logic       running,
   output logic       wrapped,
   output logic       lap_active
);
   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = $clog2(DIV);
   localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
   state_t state, next_state;

   logic [1:0]    start_sync, clear_sync;
   logic          start_prev, clear_prev;
   logic          start_pulse, clear_pulse;
   logic [PW-1:0] presc;
   logic [3:0]    h0, h1, s0, s1;
   logic [3:0]    h0_nx, h1_nx, s0_nx, s1_nx;
   logic          tick, at_max, do_clear, lap_req;
   logic [15:0]   live_bcd, shown_bcd;

   always_ff @(posedge clk_50MHz or negedge rst_n) begin
      if (!rst_n) begin
         start_sync <= '0;
         clear_sync <= '0;
         start_prev <= 1'b0;
         clear_prev <= 1'b0;
      end else begin
         start_sync <= {start_sync[0], btn_start};
         clear_sync <= {clear_sync[0], btn_clear};
         start_prev <= start_sync[1];
         clear_prev <= clear_sync[1];
      end
   end

   assign start_pulse = start_sync[1] & ~start_prev;
   assign clear_pulse = clear_sync[1] & ~clear_prev;

   always_ff @(posedge clk_50MHz or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // Clear has priority when stopped; start has priority while running.
   always_comb begin
      next_state = state;
      do_clear   = 1'b0;
      lap_req    = 1'b0;
      case (state)
         IDLE: begin
            if (clear_pulse)      do_clear = 1'b1;
            else if (start_pulse) next_state = RUN;
         end
         RUN: begin
            if (start_pulse)      next_state = PAUSE;
            else if (clear_pulse) lap_req = 1'b1;
         end
         PAUSE: begin
            if (clear_pulse) begin
               next_state = IDLE;
               do_clear   = 1'b1;
            end else if (start_pulse) begin
               next_state = RUN;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   assign tick   = (state == RUN) && (presc == PRESC_MAX);
   assign at_max = (h0 == 4'd9) && (h1 == 4'd9) && (s0 == 4'd9) && (s1 == 4'd5);

   always_comb begin
      h0_nx = h0;
      h1_nx = h1;
      s0_nx = s0;
      s1_nx = s1;
      if (tick) begin
         if (h0 != 4'd9) h0_nx = h0 + 4'd1;
         else begin
            h0_nx = 4'd0;
            if (h1 != 4'd9) h1_nx = h1 + 4'd1;
            else begin
               h1_nx = 4'd0;
               if (s0 != 4'd9) s0_nx = s0 + 4'd1;
               else begin
                  s0_nx = 4'd0;
                  s1_nx = (s1 == 4'd5) ? 4'd0 : s1 + 4'd1;
               end
            end
         end
      end
   end

   // Prescaler holds its value in PAUSE so a resume keeps the fractional hundredth.
   always_ff @(posedge clk_50MHz or negedge rst_n) begin
      if (!rst_n) begin
         presc   <= '0;
         h0      <= 4'd0;
         h1      <= 4'd0;
         s0      <= 4'd0;
         s1      <= 4'd0;
         wrapped <= 1'b0;
      end else begin
         wrapped <= tick & at_max;
         if (do_clear) begin
            presc <= '0;
            h0    <= 4'd0;
            h1    <= 4'd0;
            s0    <= 4'd0;
            s1    <= 4'd0;
         end else if (state == RUN) begin
            presc <= tick ? '0 : presc + 1'b1;
            h0    <= h0_nx;
            h1    <= h1_nx;
            s0    <= s0_nx;
            s1    <= s1_nx;
         end
      end
   end

   assign live_bcd = {s1, s0, h1, h0};

`ifdef LAP_HOLD_EN
   logic [15:0] lap_bcd;

   always_ff @(posedge clk_50MHz or negedge rst_n) begin
      if (!rst_n) begin
         lap_active <= 1'b0;
         lap_bcd    <= '0;
      end else if (next_state != RUN) begin
         lap_active <= 1'b0;
      end else if (lap_req) begin
         lap_active <= ~lap_active;
         if (!lap_active) lap_bcd <= live_bcd;
      end
   end

   assign shown_bcd = lap_active ? lap_bcd : live_bcd;
`else
   assign lap_active = 1'b0;
   assign shown_bcd  = live_bcd;
`endif

   always_ff @(posedge clk_50MHz or negedge rst_n) begin
      if (!rst_n) begin
         data_digit0 <= 5'h10;
         data_digit1 <= 5'h10;
         data_digit2 <= 5'h00;
         data_digit3 <= 5'h10;
      end else begin
         data_digit0 <= {1'b1, shown_bcd[3:0]};
         data_digit1 <= {1'b1, shown_bcd[7:4]};
         data_digit2 <= {1'b0, shown_bcd[11:8]};
         data_digit3 <= {1'b1, shown_bcd[15:12]};
      end
   end

   assign running = (state == RUN);

endmodule

// File: tb/tb_sev_seg_stopwatch.sv
// tb/tb_sev_seg_stopwatch.sv - directed bench for sev_seg_stopwatch at CLK_HZ=1000, TICK_HZ=100
module tb_sev_seg_stopwatch;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn_start = 1'b0;
   logic       btn_clear = 1'b0;
   logic [4:0] data_digit0, data_digit1, data_digit2, data_digit3;
   logic       running, wrapped, lap_active;

   int n_vec = 0;
   int n_bad = 0;
   int t = 0;
   int wrap_cnt = 0;

`ifdef LAP_HOLD_EN
   localparam bit LAP = 1'b1;
`else
   localparam bit LAP = 1'b0;
`endif

   sev_seg_stopwatch #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
      .clk_50MHz  (clk),
      .rst_n      (rst_n),
      .btn_start  (btn_start),
      .btn_clear  (btn_clear),
      .data_digit0(data_digit0),
      .data_digit1(data_digit1),
      .data_digit2(data_digit2),
      .data_digit3(data_digit3),
      .running    (running),
      .wrapped    (wrapped),
      .lap_active (lap_active)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (wrapped === 1'b1) wrap_cnt++;

   function automatic logic [15:0] disp();
      return {data_digit3[3:0], data_digit2[3:0], data_digit1[3:0], data_digit0[3:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance to the negedge following edge k (edges counted from the first start).
   task automatic goto(input int k);
      repeat (k - t) @(posedge clk);
      t = k;
      @(negedge clk);
   endtask

   // Button effect lands on the third rising edge after assertion.
   task automatic press(input logic s, input logic c, input int hold);
      btn_start = s;
      btn_clear = c;
      repeat (3 + hold) @(posedge clk);
      t += 3 + hold;
      @(negedge clk);
      btn_start = 1'b0;
      btn_clear = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_d0", data_digit0, 5'h10);
      check("rst_d1", data_digit1, 5'h10);
      check("rst_d2", data_digit2, 5'h00);
      check("rst_d3", data_digit3, 5'h10);
      check("rst_run", running, 1'b0);
      check("rst_lap", lap_active, 1'b0);
      rst_n = 1'b1;

      t = -3;
      press(1'b1, 1'b0, 0);
      check("start_run", running, 1'b1);
      goto(1001);
      check("count_100", disp(), 16'h0100);
      check("count_run", running, 1'b1);
      check("count_nowrap", wrap_cnt, 0);

      goto(59991);
      check("wrap_5999", disp(), 16'h5999);
      check("wrap_none_yet", wrap_cnt, 0);
      goto(60000);
      check("wrap_pulse", wrapped, 1'b1);
      goto(60001);
      check("wrap_zero", disp(), 16'h0000);
      check("wrap_low", wrapped, 1'b0);
      check("wrap_once", wrap_cnt, 1);
      check("wrap_run", running, 1'b1);

      goto(60051);
      press(1'b0, 1'b1, 0);
      goto(60101);
      check("clr_run_1", disp(), LAP ? 16'h0005 : 16'h0010);
      check("lap_on", lap_active, LAP);
      press(1'b0, 1'b1, 0);
      goto(60105);
      check("clr_run_2", disp(), 16'h0010);
      check("lap_off", lap_active, 1'b0);
      press(1'b0, 1'b1, 0);
      goto(60201);
      check("clr_run_3", disp(), LAP ? 16'h0010 : 16'h0020);
      check("lap_on2", lap_active, LAP);

      goto(60373);
      press(1'b1, 1'b0, 0);
      goto(60377);
      check("pause_run", running, 1'b0);
      check("pause_lap", lap_active, 1'b0);
      check("pause_37", disp(), 16'h0037);
      goto(60876);
      check("pause_hold", disp(), 16'h0037);
      press(1'b1, 1'b0, 0);
      goto(60883);
      check("resume_pre", disp(), 16'h0037);
      goto(60884);
      check("resume_38", disp(), 16'h0038);
      check("resume_run", running, 1'b1);

      press(1'b1, 1'b0, 50);
      goto(61000);
      check("held_run", running, 1'b0);
      check("held_38", disp(), 16'h0038);

      press(1'b0, 1'b1, 0);
      goto(61004);
      check("clr_pause", disp(), 16'h0000);
      check("clr_idle", running, 1'b0);
      press(1'b0, 1'b1, 0);
      goto(61010);
      check("clr_idle_noop", disp(), 16'h0000);

      press(1'b1, 1'b0, 0);
      goto(61050);
      press(1'b1, 1'b1, 0);
      goto(61060);
      check("both_run_st", running, 1'b0);
      check("both_run_tick", disp(), 16'h0004);
      press(1'b1, 1'b1, 0);
      goto(61065);
      check("both_pause_st", running, 1'b0);
      check("both_pause_clr", disp(), 16'h0000);

      press(1'b1, 1'b0, 0);
      goto(61200);
      check("prerst_13", disp(), 16'h0013);
      rst_n = 1'b0;
      #1;
      check("arst_d0", data_digit0, 5'h10);
      check("arst_d1", data_digit1, 5'h10);
      check("arst_d2", data_digit2, 5'h00);
      check("arst_d3", data_digit3, 5'h10);
      check("arst_run", running, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (50) @(posedge clk);
      @(negedge clk);
      check("postrst_disp", disp(), 16'h0000);
      check("postrst_run", running, 1'b0);
      check("final_wraps", wrap_cnt, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
